// File: rtl/imem_load_ctrl.sv
// Instruction memory owner: loads a program from a valid/ready stream, holds the core through a
// fixed flush, then serves 1-cycle fetches. Define IMEM_BOUNDS_CHK_EN to fault out-of-range PCs.
module imem_load_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [31:0] NOP         = 32'h0000_0013,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_done,
  output logic [AW:0]   ld_count,
  output logic          core_hold,
  input  logic          if_req,
  input  logic [31:0]   if_pc,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic          fetch_fault,
  output logic [1:0]    state
);

  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] wptr;
  logic [CW-1:0] hold_cnt;
  logic [31:0]   mem [DEPTH];
  logic          accept;
  logic          load_end;
  logic          start_load;
  logic          fetch_go;
  logic          pc_oob;
  logic [AW-1:0] ridx;

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_end   = 1'b0;
    start_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        accept = ld_valid;
        if (ld_valid && (ld_last || ld_count == CNTW'(DEPTH - 1))) begin
          load_end = 1'b1;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (hold_cnt == CW'(1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          start_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  assign state     = state_q;
  assign ld_ready  = (state_q == S_LOAD);
  assign core_hold = (state_q != S_RUN);

  // Load pointer, word count, flush counter and done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      ld_count <= '0;
      hold_cnt <= '0;
      ld_done  <= 1'b0;
    end else begin
      ld_done <= (state_q == S_FLUSH) && (state_d == S_RUN);
      if (start_load) begin
        wptr     <= ld_base;
        ld_count <= '0;
      end else if (accept) begin
        wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
        if (ld_count != CNTW'(DEPTH)) ld_count <= ld_count + CNTW'(1);
      end
      if (load_end)                hold_cnt <= CW'(HOLD_CYCLES);
      else if (state_q == S_FLUSH) hold_cnt <= hold_cnt - CW'(1);
    end
  end

  // Storage is deliberately left unreset so a program survives a controller reset
  always_ff @(posedge clk) begin
    if (rst && accept) mem[wptr] <= ld_data;
  end

  assign fetch_go = (state_q == S_RUN) && if_req;
  assign ridx     = if_pc[AW+1:2];

`ifdef IMEM_BOUNDS_CHK_EN
  logic       fault_q;
  logic [1:0] unused_pc_bits;
  assign pc_oob         = |if_pc[31:AW+2];
  assign unused_pc_bits = if_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fetch_go && pc_oob;
  end
  assign fetch_fault = fault_q;
`else
  logic unused_pc_bits;
  assign pc_oob         = 1'b0;
  assign unused_pc_bits = ^{if_pc[31:AW+2], if_pc[1:0]};
  assign fetch_fault    = 1'b0;
`endif

  // Fetch port: one result per request, instruction holds when idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP;
    end else begin
      if_valid <= fetch_go;
      if (fetch_go) if_instr <= pc_oob ? NOP : mem[ridx];
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl against a word-array model of the program memory.
module tb_imem_load_ctrl;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned HOLD  = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_BOUNDS_CHK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, ld_start, ld_valid, ld_last, if_req;
  logic [AW-1:0] ld_base;
  logic [31:0]   ld_data, if_pc;
  logic          ld_ready, ld_done, core_hold, if_valid, fetch_fault;
  logic [AW:0]   ld_count;
  logic [31:0]   if_instr;
  logic [1:0]    state;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] prog [$];

  imem_load_ctrl #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last), .ld_done(ld_done),
    .ld_count(ld_count), .core_hold(core_hold), .if_req(if_req), .if_pc(if_pc),
    .if_valid(if_valid), .if_instr(if_instr), .fetch_fault(fetch_fault), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  task automatic start_load(input logic [AW-1:0] base);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
    vectors++;
    if (state !== 2'd1 || ld_ready !== 1'b1 || core_hold !== 1'b1 || ld_count !== 9'd0) begin
      errors++;
      $display("FAIL start_load: state=%0d ready=%b hold=%b count=%0d exp 1/1/1/0",
               state, ld_ready, core_hold, ld_count);
    end
  endtask

  // Streams prog[] from base; checks LOAD exit, count, flush length and the done pulse
  task automatic load_words(input logic [AW-1:0] base, input int n, input bit use_last,
                            input int unsigned gap, input bit stuff_after);
    int acc = 0;
    int budget = 0;
    int expect_acc;
    logic [AW-1:0] wa;
    expect_acc = use_last ? n : ((n > int'(DEPTH)) ? int'(DEPTH) : n);
    while (acc < expect_acc && budget < 5000) begin
      budget++;
      ld_valid = ($urandom_range(99) >= gap);
      ld_data  = prog[acc];
      ld_last  = use_last && (acc == n - 1);
      ld_start = ($urandom_range(7) == 0);
      ld_base  = AW'($urandom);
      tick();
      if (ld_valid) begin
        wa = AW'(int'(base) + acc);
        model_mem[wa] = prog[acc];
        known[wa] = 1'b1;
        acc++;
      end
    end
    ld_start = 1'b0;
    ld_last  = 1'b0;
    ld_valid = stuff_after;
    ld_data  = 32'hDEAD_BEEF;
    if (acc < expect_acc) begin
      vectors++; errors++;
      $display("FAIL load_timeout: accepted %0d of %0d", acc, expect_acc);
    end
    vectors++;
    if (state !== 2'd2 || ld_ready !== 1'b0 || ld_count !== 9'(expect_acc)) begin
      errors++;
      $display("FAIL load_exit: state=%0d ready=%b count=%0d exp 2/0/%0d",
               state, ld_ready, ld_count, expect_acc);
    end
    for (int k = 1; k < int'(HOLD); k++) begin
      tick();
      vectors++;
      if (state !== 2'd2 || core_hold !== 1'b1 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin
        errors++;
        $display("FAIL flush_cycle%0d: state=%0d hold=%b ready=%b done=%b exp 2/1/0/0",
                 k, state, core_hold, ld_ready, ld_done);
      end
    end
    tick();
    ld_valid = 1'b0;
    vectors++;
    if (state !== 2'd3 || core_hold !== 1'b0 || ld_done !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: state=%0d hold=%b done=%b exp 3/0/1", state, core_hold, ld_done);
    end
    tick();
    vectors++;
    if (ld_done !== 1'b0 || ld_count !== 9'(expect_acc)) begin
      errors++;
      $display("FAIL done_pulse: done=%b count=%0d exp 0/%0d", ld_done, ld_count, expect_acc);
    end
  endtask

  // Random fetches of known words; upper PC bits randomly nonzero
  task automatic test_fetch(input int n);
    int kq[$];
    logic [31:0] last = NOP;
    logic [31:0] hi, exp_instr;
    bit req, oob;
    int idx;
    for (int a = 0; a < int'(DEPTH); a++) if (known[a]) kq.push_back(a);
    for (int i = 0; i < n; i++) begin
      req = (i == 0) || ($urandom_range(3) != 0);
      idx = kq[$urandom_range(kq.size() - 1)];
      hi  = ($urandom_range(1) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FC00);
      oob = BOUNDS && (hi != 32'h0);
      exp_instr = oob ? NOP : model_mem[idx];
      if_req = req;
      if_pc  = hi | (32'(idx) << 2) | ($urandom & 32'h3);
      tick();
      vectors++;
      if (req) begin
        if (if_valid !== 1'b1 || if_instr !== exp_instr || fetch_fault !== oob) begin
          errors++;
          $display("FAIL fetch pc=%h: valid=%b instr=%h fault=%b exp 1/%h/%b",
                   if_pc, if_valid, if_instr, fetch_fault, exp_instr, oob);
        end
        last = exp_instr;
      end else if (if_valid !== 1'b0 || if_instr !== last || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL fetch_idle: valid=%b instr=%h fault=%b exp 0/%h/0",
                 if_valid, if_instr, fetch_fault, last);
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (state !== 2'd0 || core_hold !== 1'b1 || if_valid !== 1'b0 || if_instr !== 32'h13 ||
        ld_ready !== 1'b0 || ld_done !== 1'b0 || ld_count !== 9'd0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d hold=%b valid=%b instr=%h ready=%b done=%b count=%0d fault=%b",
               state, core_hold, if_valid, if_instr, ld_ready, ld_done, ld_count, fetch_fault);
    end
    rst = 1'b1;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    vectors++;
    if (state !== 2'd0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: state=%0d ready=%b exp 0/0", state, ld_ready);
    end
  endtask

  task automatic test_basic();
    prog = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
    start_load(8'd0);
    load_words(8'd0, 3, 1'b1, 0, 1'b0);
    if_req = 1'b1;
    if_pc  = 32'd8;
    tick();
    if_req = 1'b0;
    vectors++;
    if (if_valid !== 1'b1 || if_instr !== 32'h0020_81B3) begin
      errors++;
      $display("FAIL basic_fetch: valid=%b instr=%h exp 1/002081b3", if_valid, if_instr);
    end
    tick();
    vectors++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0020_81B3) begin
      errors++;
      $display("FAIL basic_hold: valid=%b instr=%h exp 0/002081b3", if_valid, if_instr);
    end
  endtask

  task automatic test_wrap();
    prog = '{32'hAAAA_0001, 32'hBBBB_0002};
    start_load(8'd255);
    load_words(8'd255, 2, 1'b1, 30, 1'b0);
    if_req = 1'b1;
    if_pc  = 32'd1020;
    tick();
    vectors++;
    if (if_valid !== 1'b1 || if_instr !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL wrap_top: valid=%b instr=%h exp 1/aaaa0001", if_valid, if_instr);
    end
    if_pc = 32'd0;
    tick();
    if_req = 1'b0;
    vectors++;
    if (if_valid !== 1'b1 || if_instr !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL wrap_zero: valid=%b instr=%h exp 1/bbbb0002", if_valid, if_instr);
    end
  endtask

  task automatic test_full();
    logic [AW-1:0] base;
    base = AW'($urandom);
    fill_prog(300);
    start_load(base);
    load_words(base, 300, 1'b0, 20, 1'b1);
    test_fetch(40);
  endtask

  task automatic test_restart();
    int idx;
    logic [31:0] exp_instr;
    idx = int'($urandom_range(DEPTH - 1));
    exp_instr = model_mem[idx];
    if_req   = 1'b1;
    if_pc    = 32'(idx) << 2;
    ld_start = 1'b1;
    ld_base  = 8'h40;
    tick();
    ld_start = 1'b0;
    vectors++;
    if (if_valid !== 1'b1 || if_instr !== exp_instr || core_hold !== 1'b1 ||
        ld_ready !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL restart: valid=%b instr=%h hold=%b ready=%b state=%0d exp 1/%h/1/1/1",
               if_valid, if_instr, core_hold, ld_ready, state, exp_instr);
    end
    tick();
    if_req = 1'b0;
    vectors++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_in_load: valid=%b exp 0", if_valid);
    end
    fill_prog(1);
    load_words(8'h40, 1, 1'b1, 0, 1'b0);
    test_fetch(20);
  endtask

  task automatic test_bounds();
    logic [31:0] exp_instr;
    exp_instr = BOUNDS ? NOP : model_mem[0];
    if_req = 1'b1;
    if_pc  = 32'h400;
    tick();
    if_req = 1'b0;
    vectors++;
    if (if_valid !== 1'b1 || if_instr !== exp_instr || fetch_fault !== BOUNDS) begin
      errors++;
      $display("FAIL bounds: valid=%b instr=%h fault=%b exp 1/%h/%b",
               if_valid, if_instr, fetch_fault, exp_instr, BOUNDS);
    end
  endtask

  task automatic test_reset_midload();
    logic [AW-1:0] base;
    base = AW'($urandom);
    start_load(base);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      ld_last  = 1'b0;
      model_mem[AW'(int'(base) + i)] = ld_data;
      known[AW'(int'(base) + i)] = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b0;
    tick();
    vectors++;
    if (state !== 2'd0 || ld_count !== 9'd0 || core_hold !== 1'b1 || ld_ready !== 1'b0 ||
        if_valid !== 1'b0 || if_instr !== NOP) begin
      errors++;
      $display("FAIL reset_midload: state=%0d count=%0d hold=%b ready=%b valid=%b instr=%h",
               state, ld_count, core_hold, ld_ready, if_valid, if_instr);
    end
    rst = 1'b1;
    tick();
    fill_prog(1);
    start_load(AW'(base + 8'd100));
    load_words(AW'(base + 8'd100), 1, 1'b1, 0, 1'b0);
    test_fetch(30);
  endtask

  task automatic test_random_loads();
    logic [AW-1:0] base;
    int n;
    for (int it = 0; it < 4; it++) begin
      base = AW'($urandom);
      n    = int'($urandom_range(40, 1));
      fill_prog(n);
      start_load(base);
      load_words(base, n, 1'b1, $urandom_range(60), 1'b0);
      test_fetch(40);
    end
  endtask

  initial begin
    rst = 1'b0; ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; if_req = 1'b0; if_pc = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_restart();
    test_bounds();
    test_reset_midload();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
